adder_tree_pipe: RTL and testbench

- Parametrised, fully pipelined signed adder tree for the DCTQ datapath. Successor to the fixed 8-input, 12-bit, 5-stage adder.
- Sums N_IN two's-complement inputs, with a per-input runtime negate mask for butterfly sign patterns.
- Adds optional round-half-up right shift, output saturation, valid tracking, a global stall enable and asynchronous reset.
- Sits between the coefficient multipliers and the transpose/quantiser stages.

---
 rtl/adder_tree_pipe.sv | 128 ++++++++++++
 tb/tb_adder_tree_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: per-input negate, binary reduction one level per
// stage, then round-half-up shift and saturation into the output register.
module adder_tree_pipe #(
  parameter int W_IN  = 12,
  parameter int N_IN  = 8,
  parameter int SHIFT = 0,
  parameter int W_OUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [N_IN*W_IN-1:0]   in_data,
  input  logic [N_IN-1:0]        in_neg,
  output logic                   out_valid,
  output logic [W_OUT-1:0]       out_data,
  output logic                   out_sat
);

  localparam int LOG2N = $clog2(N_IN);
  localparam int WS    = W_IN + 1 + LOG2N;
  localparam int NODES = 2 * N_IN - 1;

  if ((N_IN < 2) || (N_IN > 16) || ((N_IN & (N_IN - 1)) != 0)) begin : g_bad_n_in
    $error("adder_tree_pipe: N_IN must be a power of two in 2..16");
  end
  if ((W_OUT < 2) || (W_OUT > WS - SHIFT)) begin : g_bad_w_out
    $error("adder_tree_pipe: W_OUT must satisfy 2 <= W_OUT <= WS-SHIFT");
  end
  if ((SHIFT < 0) || (SHIFT > 8)) begin : g_bad_shift
    $error("adder_tree_pipe: SHIFT must be in 0..8");
  end

  // Tree nodes are stored level by level: leaves at 0..N_IN-1, root at NODES-1.
  // Every node is held at WS bits; upper bits of shallow levels are pure sign
  // extension, so each level is effectively W_IN+1+j bits wide.
  function automatic int lvl_base(input int j);
    return 2 * N_IN - ((2 * N_IN) >> j);
  endfunction

  function automatic logic signed [WS:0] round_shift(input logic signed [WS-1:0] s);
    logic signed [WS:0] half;
    logic signed [WS:0] t;
    half = ((WS+1)'(1) << SHIFT) >> 1;
    t    = (WS+1)'(s);
    t    = t + half;
    return t >>> SHIFT;
  endfunction

  function automatic logic [W_OUT:0] saturate(input logic signed [WS:0] r);
    logic signed [WS:0] maxv;
    logic signed [WS:0] minv;
    maxv = ((WS+1)'(1) << (W_OUT - 1)) - (WS+1)'(1);
    minv = -maxv - (WS+1)'(1);
    if (r > maxv)      return {1'b1, maxv[W_OUT-1:0]};
    else if (r < minv) return {1'b1, minv[W_OUT-1:0]};
    else               return {1'b0, r[W_OUT-1:0]};
  endfunction

  logic signed [WS-1:0] node_q [NODES];
  logic signed [WS-1:0] node_d [NODES];
  logic [LOG2N:0]       vld_q, vld_d;
  logic                 out_valid_q, out_valid_d;
  logic [W_OUT-1:0]     out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;

  logic signed [W_IN-1:0] leaf_in;
  logic signed [WS-1:0]   leaf_ext;
  logic [W_OUT:0]         sat_res;

  always_comb begin
    node_d      = node_q;
    vld_d       = vld_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    leaf_in     = '0;
    leaf_ext    = '0;
    sat_res     = saturate(round_shift(node_q[NODES-1]));

    if (en) begin
      vld_d       = {vld_q[LOG2N-1:0], in_valid};
      out_valid_d = vld_q[LOG2N];

      // stage 0: sign-extend by one bit so negating the most negative input is exact
      for (int k = 0; k < N_IN; k++) begin
        leaf_in   = in_data[k*W_IN +: W_IN];
        leaf_ext  = WS'(leaf_in);
        node_d[k] = in_neg[k] ? -leaf_ext : leaf_ext;
      end

      // stages 1..LOG2N: one pairwise reduction level per register
      for (int j = 1; j <= LOG2N; j++) begin
        for (int k = 0; k < (N_IN >> j); k++) begin
          node_d[lvl_base(j) + k] = node_q[lvl_base(j-1) + 2*k]
                                  + node_q[lvl_base(j-1) + 2*k + 1];
        end
      end

      // final stage: result registers only move on a valid sample
      if (vld_q[LOG2N]) begin
        out_sat_d  = sat_res[W_OUT];
        out_data_d = sat_res[W_OUT-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NODES; n++) node_q[n] <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      for (int n = 0; n < NODES; n++) node_q[n] <= node_d[n];
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed self-checking bench for adder_tree_pipe: default instance plus a
// SHIFT=3 / W_OUT=13 instance for rounding.
module tb_adder_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en;

  logic               a_valid;
  logic [95:0]        a_data;
  logic [7:0]         a_neg;
  logic               a_out_valid;
  logic signed [14:0] a_out_data;
  logic               a_out_sat;

  logic               b_valid;
  logic [95:0]        b_data;
  logic [7:0]         b_neg;
  logic               b_out_valid;
  logic signed [12:0] b_out_data;
  logic               b_out_sat;

  int n_checks = 0;
  int n_pass   = 0;

  adder_tree_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(a_valid),
    .in_data(a_data), .in_neg(a_neg),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_sat(a_out_sat)
  );

  adder_tree_pipe #(.W_IN(12), .N_IN(8), .SHIFT(3), .W_OUT(13)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(b_valid),
    .in_data(b_data), .in_neg(b_neg),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_sat(b_out_sat)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    a_valid = 1'b0; b_valid = 1'b0; en = 1'b1;
    a_data = '0; a_neg = '0; b_data = '0; b_neg = '0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  function automatic logic [95:0] fill(input int v);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*12 +: 12] = 12'(v);
    return r;
  endfunction

  // Drives one valid sample and reports the first cycle out_valid rose and how many cycles it stayed up.
  task automatic pulse(input bit sel, input logic [95:0] data, input logic [7:0] neg,
                       output int lat, output int nvalid, output int dat, output logic sat);
    lat = -1; nvalid = 0; dat = 0; sat = 1'b0;
    if (!sel) begin a_data = data; a_neg = neg; a_valid = 1'b1; end
    else      begin b_data = data; b_neg = neg; b_valid = 1'b1; end
    for (int c = 1; c <= 10; c++) begin
      tick;
      a_valid = 1'b0; b_valid = 1'b0;
      if (sel ? b_out_valid : a_out_valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = c;
          dat = sel ? int'(b_out_data) : int'(a_out_data);
          sat = sel ? b_out_sat : a_out_sat;
        end
      end
    end
  endtask

  function automatic void model(input logic [95:0] data, input logic [7:0] neg,
                                output int r, output logic s);
    int sum;
    logic signed [11:0] x;
    sum = 0;
    for (int k = 0; k < 8; k++) begin
      x = data[k*12 +: 12];
      sum += neg[k] ? -int'(x) : int'(x);
    end
    s = 1'b0; r = sum;
    if (sum > 16383)       begin r = 16383;  s = 1'b1; end
    else if (sum < -16384) begin r = -16384; s = 1'b1; end
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_data = fill(5); a_neg = '0; b_data = '0; b_neg = '0;
    #3;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", a_out_valid); else n_pass++;
    n_checks++; if (a_out_data !== 15'sd0) $display("FAIL reset_data got=%0d want=0", a_out_data); else n_pass++;
    n_checks++; if (a_out_sat !== 1'b0) $display("FAIL reset_sat got=%b want=0", a_out_sat); else n_pass++;
    n_checks++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_valid got=%b want=0", b_out_valid); else n_pass++;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      n_checks++; if (a_out_valid !== 1'b0) $display("FAIL idle_valid cyc=%0d got=%b want=0", c, a_out_valid); else n_pass++;
    end
  endtask

  task automatic test_max_sum;
    int lat, nv, dat; logic sat;
    apply_reset;
    pulse(1'b0, fill(2047), 8'h00, lat, nv, dat, sat);
    n_checks++; if (lat !== 5) $display("FAIL max_latency got=%0d want=5", lat); else n_pass++;
    n_checks++; if (nv !== 1) $display("FAIL max_valid_cycles got=%0d want=1", nv); else n_pass++;
    n_checks++; if (dat !== 16376) $display("FAIL max_data got=%0d want=16376", dat); else n_pass++;
    n_checks++; if (sat !== 1'b0) $display("FAIL max_sat got=%b want=0", sat); else n_pass++;
  endtask

  task automatic test_min_and_sat;
    int lat, nv, dat; logic sat;
    apply_reset;
    pulse(1'b0, fill(-2048), 8'h00, lat, nv, dat, sat);
    n_checks++; if (lat !== 5) $display("FAIL min_latency got=%0d want=5", lat); else n_pass++;
    n_checks++; if (dat !== -16384) $display("FAIL min_data got=%0d want=-16384", dat); else n_pass++;
    n_checks++; if (sat !== 1'b0) $display("FAIL min_sat got=%b want=0", sat); else n_pass++;
    pulse(1'b0, fill(-2048), 8'hFF, lat, nv, dat, sat);
    n_checks++; if (lat !== 5) $display("FAIL negmin_latency got=%0d want=5", lat); else n_pass++;
    n_checks++; if (dat !== 16383) $display("FAIL negmin_data got=%0d want=16383", dat); else n_pass++;
    n_checks++; if (sat !== 1'b1) $display("FAIL negmin_sat got=%b want=1", sat); else n_pass++;
  endtask

  task automatic test_round;
    int vals [5] = '{3, -3, 1, 1, -1};
    int cnt  [5] = '{4, 4, 4, 3, 4};
    int expd [5] = '{2, -1, 1, 0, 0};
    int lat, nv, dat; logic sat;
    logic [95:0] d;
    apply_reset;
    for (int i = 0; i < 5; i++) begin
      d = '0;
      for (int k = 0; k < cnt[i]; k++) d[k*12 +: 12] = 12'(vals[i]);
      pulse(1'b1, d, 8'h00, lat, nv, dat, sat);
      n_checks++; if (lat !== 5) $display("FAIL round_latency vec=%0d got=%0d want=5", i, lat); else n_pass++;
      n_checks++; if (dat !== expd[i]) $display("FAIL round_data vec=%0d got=%0d want=%0d", i, dat, expd[i]); else n_pass++;
      n_checks++; if (sat !== 1'b0) $display("FAIL round_sat vec=%0d got=%b want=0", i, sat); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [95:0] vd [20];
    logic [7:0]  vn [20];
    bit          vv [20];
    int          ed [20];
    logic        es [20];
    int last_d; logic last_s; int i;
    apply_reset;
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 8; k++) vd[n][k*12 +: 12] = 12'($urandom_range(0, 4095));
      vn[n] = 8'($urandom_range(0, 255));
      vv[n] = (n % 3) != 2;
      if (n == 7) begin vd[n] = fill(-2048); vn[n] = 8'hFF; end
      model(vd[n], vn[n], ed[n], es[n]);
    end
    last_d = 0; last_s = 1'b0;
    for (int t = 0; t < 26; t++) begin
      if (t < 20) begin a_data = vd[t]; a_neg = vn[t]; a_valid = vv[t]; end
      else        begin a_valid = 1'b0; a_data = '0; end
      tick;
      i = t - 4;
      if (i < 0) begin
        n_checks++; if (a_out_valid !== 1'b0) $display("FAIL b2b_fill_valid t=%0d got=%b want=0", t, a_out_valid); else n_pass++;
      end else if (i < 20) begin
        n_checks++; if (a_out_valid !== vv[i]) $display("FAIL b2b_valid idx=%0d got=%b want=%b", i, a_out_valid, vv[i]); else n_pass++;
        if (vv[i]) begin last_d = ed[i]; last_s = es[i]; end
        n_checks++; if (a_out_data !== last_d) $display("FAIL b2b_data idx=%0d got=%0d want=%0d", i, a_out_data, last_d); else n_pass++;
        n_checks++; if (a_out_sat !== last_s) $display("FAIL b2b_sat idx=%0d got=%b want=%b", i, a_out_sat, last_s); else n_pass++;
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic test_stall;
    logic [95:0] sd [4];
    logic [7:0]  sn [4];
    int          sv [4] = '{8, -4, -8, 6000};
    int exp_idx [17] = '{-1, -1, -1, -1, -1, -1, -1, -1, 0, 0, 0, 1, 2, 3, -3, -3, -3};
    int want_d; logic want_v;
    apply_reset;
    sd[0] = fill(1);    sn[0] = 8'h00;
    sd[1] = '0;
    for (int k = 0; k < 8; k++) sd[1][k*12 +: 12] = 12'(k);
    sn[1] = 8'hAA;
    sd[2] = fill(-1);   sn[2] = 8'h00;
    sd[3] = fill(1000); sn[3] = 8'h01;
    for (int e = 1; e <= 16; e++) begin
      en = !((e >= 5 && e <= 7) || (e >= 9 && e <= 10));
      if (e <= 4) begin a_data = sd[e-1]; a_neg = sn[e-1]; a_valid = 1'b1; end
      else        begin a_valid = 1'b0; a_data = fill(77); end
      tick;
      want_v = exp_idx[e] >= 0;
      if (exp_idx[e] >= 0)       want_d = sv[exp_idx[e]];
      else if (exp_idx[e] == -3) want_d = sv[3];
      else                       want_d = 0;
      n_checks++; if (a_out_valid !== want_v) $display("FAIL stall_valid edge=%0d got=%b want=%b", e, a_out_valid, want_v); else n_pass++;
      n_checks++; if (a_out_data !== want_d) $display("FAIL stall_data edge=%0d got=%0d want=%0d", e, a_out_data, want_d); else n_pass++;
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset;
    int lat, nv, dat; logic sat;
    apply_reset;
    a_data = fill(1); a_neg = 8'h00; a_valid = 1'b1;
    for (int c = 0; c < 7; c++) tick;
    n_checks++; if (a_out_valid !== 1'b1) $display("FAIL prereset_valid got=%b want=1", a_out_valid); else n_pass++;
    n_checks++; if (a_out_data !== 15'sd8) $display("FAIL prereset_data got=%0d want=8", a_out_data); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL async_valid got=%b want=0", a_out_valid); else n_pass++;
    n_checks++; if (a_out_data !== 15'sd0) $display("FAIL async_data got=%0d want=0", a_out_data); else n_pass++;
    n_checks++; if (a_out_sat !== 1'b0) $display("FAIL async_sat got=%b want=0", a_out_sat); else n_pass++;
    a_valid = 1'b0;
    @(posedge clk);
    #4 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick;
      n_checks++; if (a_out_valid !== 1'b0) $display("FAIL stale_valid cyc=%0d got=%b want=0", c, a_out_valid); else n_pass++;
    end
    pulse(1'b0, fill(3), 8'h00, lat, nv, dat, sat);
    n_checks++; if (lat !== 5) $display("FAIL postreset_latency got=%0d want=5", lat); else n_pass++;
    n_checks++; if (dat !== 24) $display("FAIL postreset_data got=%0d want=24", dat); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_max_sum;
    test_min_and_sat;
    test_round;
    test_back_to_back;
    test_stall;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
